// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for inv_sub_bytes_seq: input state offer and output result.
// The master side is the upstream/downstream pair; the slave side is the sequencer.
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid,
    output in_state,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state
  );

  modport slave (
    input  in_valid,
    input  in_state,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// AES inverse SubBytes sequencer. A 128-bit state is pushed through LANES shared
// inverse S-box lanes (ROMs live outside this block) over 16/LANES cycles.
// Byte j of a state is bits [127-8j -: 8]; byte 0 is the MSB byte.
module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  inv_sub_bytes_seq_if.slave   bus_io,
  output logic                 busy_o,
  output logic [8*LANES-1:0]   sbox_sel_o,
  input  logic [8*LANES-1:0]   sbox_out_i
);

  localparam int unsigned N    = 16 / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  // Only lane counts that divide the 16 bytes evenly are supported.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gen_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Packed element 15 is the MSB byte, so state byte j lives at element 15-j.
  logic [15:0][7:0] src_buf_q, src_buf_d;
  logic [15:0][7:0] res_buf_q, res_buf_d;
  logic [3:0]       byte_idx;
  logic             run_last;

  assign run_last = (cnt_q == CntW'(N - 1));

  // Next-state, datapath update and S-box lane selection.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_buf_d  = src_buf_q;
    res_buf_d  = res_buf_q;
    sbox_sel_o = '0;
    byte_idx   = '0;

    case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          src_buf_d = bus_io.in_state;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end

      StRun: begin
        for (int unsigned k = 0; k < LANES; k++) begin
          byte_idx                    = 4'(32'(cnt_q) * LANES + k);
          sbox_sel_o[8*k +: 8]        = src_buf_q[4'd15 - byte_idx];
          res_buf_d[4'd15 - byte_idx] = sbox_out_i[8*k +: 8];
        end
        if (run_last) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        if (bus_io.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and buffer registers; reset drops any block in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      src_buf_q <= '0;
      res_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_buf_q <= src_buf_d;
      res_buf_q <= res_buf_d;
    end
  end

  // Handshake outputs decode registered state only; no in_valid/out_ready paths.
  assign bus_io.in_ready  = (state_q == StIdle);
  assign bus_io.out_valid = (state_q == StDone);
  assign bus_io.out_state = res_buf_q;
  assign busy_o           = (state_q != StIdle);

  // A presented result must not move until it is taken.
  a_out_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    bus_io.out_valid && !bus_io.out_ready |=> bus_io.out_valid && $stable(bus_io.out_state));

  // The lanes are only addressed while the block is running.
  a_sel_quiet: assert property (@(posedge clk_i)
    (state_q != StRun) |-> (sbox_sel_o == '0));

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq with LANES = 4, 1 and 16 instances.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_sub_bytes_seq_if bus4 ();
  inv_sub_bytes_seq_if bus1 ();
  inv_sub_bytes_seq_if bus16 ();

  logic [31:0]  sel4,  sbo4;
  logic [7:0]   sel1,  sbo1;
  logic [127:0] sel16, sbo16;
  logic         busy4, busy1, busy16;

  logic [7:0] inv_rom [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  for (genvar k = 0; k < 4; k++) begin : g_rom4
    assign sbo4[8*k +: 8] = inv_rom[sel4[8*k +: 8]];
  end
  for (genvar k = 0; k < 16; k++) begin : g_rom16
    assign sbo16[8*k +: 8] = inv_rom[sel16[8*k +: 8]];
  end
  assign sbo1 = inv_rom[sel1];

  inv_sub_bytes_seq #(.LANES(4)) u_dut4 (
    .clk_i      (clk),
    .reset_i    (reset),
    .bus_io     (bus4.slave),
    .busy_o     (busy4),
    .sbox_sel_o (sel4),
    .sbox_out_i (sbo4)
  );

  inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
    .clk_i      (clk),
    .reset_i    (reset),
    .bus_io     (bus1.slave),
    .busy_o     (busy1),
    .sbox_sel_o (sel1),
    .sbox_out_i (sbo1)
  );

  inv_sub_bytes_seq #(.LANES(16)) u_dut16 (
    .clk_i      (clk),
    .reset_i    (reset),
    .bus_io     (bus16.slave),
    .busy_o     (busy16),
    .sbox_sel_o (sel16),
    .sbox_out_i (sbo16)
  );

  localparam logic [127:0] V1  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] E1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] S52 = {16{8'h52}};
  localparam logic [127:0] S48 = {16{8'h48}};
  localparam logic [127:0] SA  = {16{8'h63}};
  localparam logic [127:0] SB  = {16{8'h7c}};
  localparam logic [127:0] EB  = {16{8'h01}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Lane k of a LANES=4 selector carries source byte 4c+k.
  function automatic logic [31:0] exp_sel4(input logic [127:0] v, input int c);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = v[127 - 8*(4*c + k) -: 8];
    return r;
  endfunction

  // One block through the 4-lane instance with out_ready high; starts and ends idle.
  task automatic run4(input string tag, input logic [127:0] v, input logic [127:0] e);
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 1'b1;
    bus4.in_state  = v;
    check_eq({tag, "_ready_pre"}, 128'(bus4.in_ready), 128'(1));
    tick();
    bus4.in_valid = 1'b0;
    bus4.in_state = '0;
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("%s_ready_run%0d", tag, c), 128'(bus4.in_ready), 128'(0));
      check_eq($sformatf("%s_valid_run%0d", tag, c), 128'(bus4.out_valid), 128'(0));
      check_eq($sformatf("%s_busy_run%0d", tag, c), 128'(busy4), 128'(1));
      check_eq($sformatf("%s_sel_run%0d", tag, c), 128'(sel4), 128'(exp_sel4(v, c)));
      tick();
    end
    check_eq({tag, "_valid_done"}, 128'(bus4.out_valid), 128'(1));
    check_eq({tag, "_state_done"}, bus4.out_state, e);
    check_eq({tag, "_sel_done"}, 128'(sel4), 128'(0));
    check_eq({tag, "_ready_done"}, 128'(bus4.in_ready), 128'(0));
    tick();
    check_eq({tag, "_ready_post"}, 128'(bus4.in_ready), 128'(1));
    check_eq({tag, "_valid_post"}, 128'(bus4.out_valid), 128'(0));
    check_eq({tag, "_busy_post"}, 128'(busy4), 128'(0));
    check_eq({tag, "_sel_post"}, 128'(sel4), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int t_acc [2];
    logic [127:0] outs [2];
    int n_acc;
    int n_out;
    int lat;
    logic [127:0] rev;

    reset = 1'b1;
    bus4.in_valid  = 1'b0; bus4.in_state  = '0; bus4.out_ready  = 1'b0;
    bus1.in_valid  = 1'b0; bus1.in_state  = '0; bus1.out_ready  = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_state = '0; bus16.out_ready = 1'b0;
    t_acc = '{0, 0};
    outs  = '{128'h0, 128'h0};
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_in_ready", 128'(bus4.in_ready), 128'(1));
    check_eq("rst_out_valid", 128'(bus4.out_valid), 128'(0));
    check_eq("rst_busy", 128'(busy4), 128'(0));
    check_eq("rst_out_state", bus4.out_state, 128'h0);
    check_eq("rst_sel", 128'(sel4), 128'(0));

    // Standard vector, out_ready high
    run4("s1", V1, E1);

    // Stalled output with in_valid and in_state churning
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_state  = S52;
    tick();
    for (int c = 0; c < 4; c++) begin
      bus4.in_state = V1 ^ {16{8'(c)}};
      check_eq($sformatf("s2_sel_run%0d", c), 128'(sel4), 128'(32'h52525252));
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      bus4.in_state = {$urandom, $urandom, $urandom, $urandom};
      check_eq($sformatf("s2_valid_hold%0d", i), 128'(bus4.out_valid), 128'(1));
      check_eq($sformatf("s2_ready_hold%0d", i), 128'(bus4.in_ready), 128'(0));
      check_eq($sformatf("s2_state_hold%0d", i), bus4.out_state, S48);
      tick();
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    check_eq("s2_valid_release", 128'(bus4.out_valid), 128'(1));
    tick();
    check_eq("s2_ready_after", 128'(bus4.in_ready), 128'(1));
    check_eq("s2_valid_after", 128'(bus4.out_valid), 128'(0));

    // Reset in the second RUN cycle
    bus4.in_valid = 1'b1;
    bus4.in_state = V1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    check_eq("s3_sel_run1", 128'(sel4), 128'(exp_sel4(V1, 1)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("s3_ready_rst", 128'(bus4.in_ready), 128'(1));
    check_eq("s3_valid_rst", 128'(bus4.out_valid), 128'(0));
    check_eq("s3_state_rst", bus4.out_state, 128'h0);
    check_eq("s3_sel_rst", 128'(sel4), 128'(0));
    run4("s3b", 128'h0, S52);

    // Back-to-back blocks with in_valid and out_ready held high
    n_acc = 0;
    n_out = 0;
    bus4.in_valid  = 1'b1;
    bus4.in_state  = SA;
    bus4.out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (bus4.in_valid && bus4.in_ready) begin
        if (n_acc < 2) t_acc[n_acc] = t;
        n_acc++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        if (n_out < 2) outs[n_out] = bus4.out_state;
        n_out++;
      end
      tick();
      if (n_acc == 1) bus4.in_state = SB;
      else if (n_acc >= 2) bus4.in_valid = 1'b0;
    end
    check_eq("s4_accepts", 128'(n_acc), 128'(2));
    check_eq("s4_accept_gap", 128'(t_acc[1] - t_acc[0]), 128'(6));
    check_eq("s4_outputs", 128'(n_out), 128'(2));
    check_eq("s4_out_a", outs[0], 128'h0);
    check_eq("s4_out_b", outs[1], EB);

    // Single-lane instance: 16-cycle latency
    bus1.in_valid  = 1'b1;
    bus1.in_state  = V1;
    bus1.out_ready = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    check_eq("s5_l1_sel0", 128'(sel1), 128'(8'h63));
    check_eq("s5_l1_busy", 128'(busy1), 128'(1));
    lat = 0;
    while (!bus1.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("s5_l1_latency", 128'(lat), 128'(16));
    check_eq("s5_l1_state", bus1.out_state, E1);
    tick();

    // Sixteen-lane instance: 1-cycle latency, every byte in one shot
    for (int k = 0; k < 16; k++) rev[8*k +: 8] = V1[127 - 8*k -: 8];
    bus16.in_valid  = 1'b1;
    bus16.in_state  = V1;
    bus16.out_ready = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    check_eq("s5_l16_sel", sel16, rev);
    check_eq("s5_l16_busy", 128'(busy16), 128'(1));
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check_eq("s5_l16_latency", 128'(lat), 128'(1));
    check_eq("s5_l16_state", bus16.out_state, E1);
    check_eq("s5_l16_sel_done", sel16, 128'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
